alu_op_sequencer: RTL
=====================

// Module: alu_op_sequencer
// PURPOSE
//  Front-end controller for the TotalALU datapath: accepts one operation per request over a valid/ready handshake.
//  Drives Signal/dataA/dataB into the datapath, holds them for the multi-cycle MULTU, samples Output and
//  returns the result over a valid/ready response channel. Sits between issue logic and TotalALU; sole owner of its inputs.
// PARAMETERS
//  MUL_CYCLES  32  cycles Signal/operands held stable for MULTU before HiLo is valid
//  RES_LAT     1   cycles from driving a single-cycle op to sampling alu_result (covers registered control)
// PORTS
//  clk          in   1   clock, rising edge
//  reset        in   1   asynchronous, active-low reset
//  req_valid    in   1   request present
//  req_ready    out  1   sequencer can accept (high only in IDLE)
//  req_funct    in   6   funct code: AND 36, OR 37, ADD 32, SUB 34, SLT 42, SRL 2, MULTU 25, MFHI 16, MFLO 18
//  req_a        in   32  operand A
//  req_b        in   32  operand B
//  rsp_valid    out  1   response present; held until rsp_ready
//  rsp_ready    in   1   consumer accepts response
//  rsp_data     out  32  result (0 for MULTU ack and for errors)
//  rsp_err      out  1   illegal funct, or MFHI/MFLO with no completed MULTU since reset
//  alu_signal   out  6   to datapath Signal; 6'd0 when idle
//  alu_dataA    out  32  to datapath dataA
//  alu_dataB    out  32  to datapath dataB
//  alu_result   in   32  from datapath Output
//  busy         out  1   high in any state other than IDLE
// BEHAVIOUR
//  Reset: state=IDLE, req_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, alu_signal=0, alu_dataA/B=0, busy=0, hilo_valid=0.
//  States: IDLE, ISSUE, MUL_WAIT, RESP.
//  IDLE: on req_valid&req_ready, latch funct and operands.
//  - Legal single-cycle op or MFHI/MFLO with hilo_valid=1: go to ISSUE.
//  - MULTU: go to MUL_WAIT.
//  - Illegal funct, or MFHI/MFLO with hilo_valid=0: go directly to RESP with rsp_err=1, rsp_data=0; datapath not driven.
//  ISSUE: drive alu_signal/dataA/dataB for RES_LAT cycles; sample alu_result on the last cycle into rsp_data;
//  then go to RESP. Latency with RES_LAT=1: handshake at T, drive at T+1, rsp_valid at T+2.
//  MUL_WAIT: hold alu_signal=25 and operands stable for exactly MUL_CYCLES cycles (down-counter);
//  then set hilo_valid=1, rsp_data=0, rsp_err=0, go to RESP.
//  RESP: rsp_valid=1, alu_signal=0; rsp_data/rsp_err stable until rsp_ready. On handshake go to IDLE.
//  - req_ready becomes 1 the cycle after the response handshake (no same-cycle request/response overlap).
//  Operands driven to datapath are only the latched copies; req_a/req_b changes after accept have no effect.
//  hilo_valid stays set until reset; a new MULTU overwrites HI/LO and keeps hilo_valid=1.
//  Reset mid-operation (any state): immediate return to reset values; in-flight op dropped, no response.
//  rsp_ready asserted while rsp_valid=0: ignored. req_valid while busy: ignored, not queued.
// CONFIGURATION
//  ALU_SEQ_BUSY_CNT_EN defined:
//  - adds output mul_busy_cnt [15:0]: counts cycles spent in MUL_WAIT, saturates at 16'hFFFF.
//  - cleared only by reset.
//  Not defined: port absent, no counter logic.
// STRUCTURE
//  Package alu_seq_pkg:
//  - funct localparams (FN_AND, FN_OR, FN_ADD, FN_SUB, FN_SLT, FN_SRL, FN_MULTU, FN_MFHI, FN_MFLO)
//  - state enum (ST_IDLE, ST_ISSUE, ST_MUL_WAIT, ST_RESP)
//  - NOP signal constant 6'd0
//  Sub-module alu_seq_decode: combinational funct classifier; outputs is_single, is_mul, is_mfhilo, is_illegal.
// TESTING
//  1. ADD a=5, b=7, rsp_ready=1 -> rsp_valid at T+2, rsp_data=12, rsp_err=0.
//  2. MFLO right after reset -> rsp_err=1, rsp_data=0, alu_signal stays 0 throughout.
//  3. MULTU a=32'h0001_0000, b=32'h0001_0000 -> alu_signal=25 for exactly 32 cycles, ack rsp_data=0;
//     then MFHI -> 1, MFLO -> 0.
//  4. funct=6'd63 -> rsp_err=1, rsp_data=0; next request (SUB 3,5) -> 32'hFFFF_FFFE.
//  5. SLT a=-1, b=1 with rsp_ready low 4 cycles -> rsp_valid and rsp_data=1 held stable; req_ready=0 until handshake.
//  6. Assert reset low at cycle 10 of MULTU -> all outputs at reset values, busy=0, no response;
//     following MFHI -> rsp_err=1.

Source files
------------

// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_pkg
// Description : Shared funct codes, FSM state encoding and the idle datapath
//               control value for the TotalALU front-end sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    // Datapath funct codes understood by TotalALU
    localparam logic [5:0] FN_AND   = 6'd36;
    localparam logic [5:0] FN_OR    = 6'd37;
    localparam logic [5:0] FN_ADD   = 6'd32;
    localparam logic [5:0] FN_SUB   = 6'd34;
    localparam logic [5:0] FN_SLT   = 6'd42;
    localparam logic [5:0] FN_SRL   = 6'd2;
    localparam logic [5:0] FN_MULTU = 6'd25;
    localparam logic [5:0] FN_MFHI  = 6'd16;
    localparam logic [5:0] FN_MFLO  = 6'd18;

    // Control value presented to the datapath whenever no op is in flight
    localparam logic [5:0] FN_NOP   = 6'd0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_MUL_WAIT = 2'd2,
        ST_RESP     = 2'd3
    } seqState_t;

endpackage
`default_nettype wire

// File: rtl/alu_seq_decode.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_decode
// Description : Combinational funct classifier. Exactly one output is high
//               for any funct value.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_decode
    import alu_seq_pkg::*;
(
    input  logic [5:0] funct,
    output logic       is_single,
    output logic       is_mul,
    output logic       is_mfhilo,
    output logic       is_illegal
);

    // Sort the funct code into the four handling classes
    always_comb begin
        is_single  = 1'b0;
        is_mul     = 1'b0;
        is_mfhilo  = 1'b0;
        is_illegal = 1'b0;
        case (funct)
            FN_AND, FN_OR, FN_ADD, FN_SUB, FN_SLT, FN_SRL: is_single = 1'b1;
            FN_MULTU:                                      is_mul    = 1'b1;
            FN_MFHI, FN_MFLO:                              is_mfhilo = 1'b1;
            default:                                       is_illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_sequencer
// Description : Front-end controller for the TotalALU datapath. Accepts one
//               op per request handshake, drives the datapath from latched
//               operands (holding them MUL_CYCLES cycles for MULTU), samples
//               the result and returns it over a response handshake.
//               Optional macro ALU_SEQ_BUSY_CNT_EN adds the saturating
//               mul_busy_cnt output counting cycles spent in MUL_WAIT.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int MUL_CYCLES = 32,
    parameter int RES_LAT    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_funct,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic [5:0]  alu_signal,
    output logic [31:0] alu_dataA,
    output logic [31:0] alu_dataB,
    input  logic [31:0] alu_result,
    output logic        busy
`ifdef ALU_SEQ_BUSY_CNT_EN
    ,
    output logic [15:0] mul_busy_cnt
`endif
);

    // One down-counter serves both ISSUE and MUL_WAIT; size it for the longer
    localparam int c_MAX_LOAD = (MUL_CYCLES > RES_LAT) ? MUL_CYCLES : RES_LAT;
    localparam int c_CNT_W    = $clog2(c_MAX_LOAD + 1);
    localparam logic [c_CNT_W-1:0] c_MUL_LOAD = c_CNT_W'(MUL_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_ISS_LOAD = c_CNT_W'(RES_LAT - 1);

    seqState_t          r_state;
    seqState_t          w_nextState;
    logic [5:0]         r_funct;
    logic [31:0]        r_opA;
    logic [31:0]        r_opB;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_hiloValid;
    logic [31:0]        r_rspData;
    logic               r_rspErr;

    logic               w_isSingle;
    logic               w_isMul;
    logic               w_isMfhilo;
    logic               w_isIllegal;
    logic               w_accept;
    logic               w_errReq;
    logic               w_drive;
    logic [5:0]         w_aluSignal;

    alu_seq_decode u_decode (
        .funct      (req_funct),
        .is_single  (w_isSingle),
        .is_mul     (w_isMul),
        .is_mfhilo  (w_isMfhilo),
        .is_illegal (w_isIllegal)
    );

    assign w_accept = req_valid && (r_state == ST_IDLE);
    // Reading HI/LO before any MULTU has finished would return stale garbage
    assign w_errReq = w_isIllegal || (w_isMfhilo && !r_hiloValid);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        w_nextState = r_state;
        w_aluSignal = FN_NOP;
        w_drive     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_errReq) begin
                        w_nextState = ST_RESP;
                    end else if (w_isMul) begin
                        w_nextState = ST_MUL_WAIT;
                    end else begin
                        w_nextState = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                w_aluSignal = r_funct;
                w_drive     = 1'b1;
                if (r_cnt == '0) begin
                    w_nextState = ST_RESP;
                end
            end
            ST_MUL_WAIT: begin
                w_aluSignal = FN_MULTU;
                w_drive     = 1'b1;
                if (r_cnt == '0) begin
                    w_nextState = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Request capture, cycle counting, result sampling and HI/LO tracking
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_funct     <= FN_NOP;
            r_opA       <= '0;
            r_opB       <= '0;
            r_cnt       <= '0;
            r_hiloValid <= 1'b0;
            r_rspData   <= '0;
            r_rspErr    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_funct   <= req_funct;
                        r_opA     <= req_a;
                        r_opB     <= req_b;
                        r_cnt     <= w_isMul ? c_MUL_LOAD : c_ISS_LOAD;
                        r_rspData <= '0;
                        r_rspErr  <= w_errReq;
                    end
                end
                ST_ISSUE: begin
                    if (r_cnt == '0) begin
                        r_rspData <= alu_result;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_MUL_WAIT: begin
                    if (r_cnt == '0) begin
                        r_hiloValid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef ALU_SEQ_BUSY_CNT_EN
    logic [15:0] r_mulBusyCnt;

    // Saturating count of cycles spent waiting on MULTU
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mulBusyCnt <= '0;
        end else if ((r_state == ST_MUL_WAIT) && (r_mulBusyCnt != 16'hFFFF)) begin
            r_mulBusyCnt <= r_mulBusyCnt + 16'd1;
        end
    end

    assign mul_busy_cnt = r_mulBusyCnt;
`endif

    // Operands only reach the datapath while an op is actually executing
    assign alu_signal = w_aluSignal;
    assign alu_dataA  = w_drive ? r_opA : 32'd0;
    assign alu_dataB  = w_drive ? r_opB : 32'd0;
    assign req_ready  = (r_state == ST_IDLE);
    assign busy       = (r_state != ST_IDLE);
    assign rsp_valid  = (r_state == ST_RESP);
    assign rsp_data   = r_rspData;
    assign rsp_err    = r_rspErr;

endmodule
`default_nettype wire
